// File: rtl/shift_issue_queue.sv
// shift_issue_queue: DEPTH-entry rotate-command FIFO feeding a combinational rotator, with a registered valid/ready result.
// Ports: clk_i / rst_ni (async active-low) clock and reset;
//   in_valid_i, o_in_ready, in_data_i, in_s_i, in_right_i : upstream command handshake;
//   o_sh_data, o_sh_s, o_sh_right : head command to rotator, sh_y_i : rotator result back;
//   o_out_valid, out_ready_i, o_out_y : registered result handshake;
//   o_count : FIFO occupancy (output register not included).
// Optional: define SHIFT_ISSUE_OPCOUNT_EN to add o_ops_done, a 16-bit wrapping count of output handshakes.
module shift_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       o_in_ready,
  input  logic [31:0]                in_data_i,
  input  logic [4:0]                 in_s_i,
  input  logic                       in_right_i,
  output logic [31:0]                o_sh_data,
  output logic [4:0]                 o_sh_s,
  output logic                       o_sh_right,
  input  logic [31:0]                sh_y_i,
  output logic                       o_out_valid,
  input  logic                       out_ready_i,
  output logic [31:0]                o_out_y,
`ifdef SHIFT_ISSUE_OPCOUNT_EN
  output logic [15:0]                o_ops_done,
`endif
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   r_data  [DEPTH];
  logic [4:0]    r_s     [DEPTH];
  logic          r_right [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [31:0]   r_out_y;
  logic          w_empty, w_push, w_cap;
  // Ready comes from registered occupancy only, so no combinational path from out_ready_i.
  assign w_empty     = (r_count == '0);
  assign o_in_ready  = (r_count != CW'(DEPTH));
  assign w_push      = in_valid_i && o_in_ready;
  assign w_cap       = !w_empty && (!r_out_valid || out_ready_i);
  assign o_sh_data   = w_empty ? 32'd0 : r_data[r_rptr];
  assign o_sh_s      = w_empty ? 5'd0  : r_s[r_rptr];
  assign o_sh_right  = w_empty ? 1'b0  : r_right[r_rptr];
  assign o_out_valid = r_out_valid;
  assign o_out_y     = r_out_y;
  assign o_count     = r_count;
  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr]  <= in_data_i;
      r_s[r_wptr]     <= in_s_i;
      r_right[r_wptr] <= in_right_i;
    end
  end
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_cap) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_cap);
      if (w_cap) begin
        r_out_valid <= 1'b1;
        r_out_y     <= sh_y_i;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`ifdef SHIFT_ISSUE_OPCOUNT_EN
  logic [15:0] r_ops_done;
  assign o_ops_done = r_ops_done;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ops_done <= 16'd0;
    else if (r_out_valid && out_ready_i) r_ops_done <= r_ops_done + 16'd1;
  end
`endif
endmodule

// File: doc/shift_issue_queue.md
# shift_issue_queue

Command front-end for the 32-bit multifunction barrel rotator. Buffers rotate requests (data, amount, direction) from an upstream producer in a DEPTH-entry FIFO and presents the head entry to the rotator's combinational inputs. Captures the rotator result into an output register with a valid/ready handshake toward the downstream consumer. Sustains one rotation per cycle under continuous flow.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  upstream command valid
- o_in_ready  output  1  queue can accept a command (not full)
- in_data_i  input  32  operand to rotate
- in_s_i  input  5  rotate amount, 0..31
- in_right_i  input  1  1 = rotate right, 0 = rotate left
- o_sh_data  output  32  head operand to rotator data_i
- o_sh_s  output  5  head amount to rotator s_i
- o_sh_right  output  1  head direction to rotator right_i
- sh_y_i  input  32  rotator result o_y (combinational return)
- o_out_valid  output  1  result register holds a valid result
- out_ready_i  input  1  downstream accepts result
- o_out_y  output  32  registered rotation result
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy, excludes output register

## Operation
- Push: in_valid_i && o_in_ready writes {in_data_i, in_s_i, in_right_i} at write pointer; pointer wraps modulo DEPTH.
- o_in_ready = (o_count != DEPTH); depends on registered count only, never on pop in same cycle (no combinational ready path from out_ready_i).
- Head drive: when o_count > 0, o_sh_* carry head entry; when empty, o_sh_* = 0.
- Capture condition: cap = (o_count > 0) && (!o_out_valid || out_ready_i).
- On cap: o_out_y <= sh_y_i, o_out_valid <= 1, read pointer advances (pop).
- Drain without cap: o_out_valid && out_ready_i && o_count == 0 → o_out_valid <= 0; o_out_y holds last value.
- Simultaneous push and pop: both take effect; o_count unchanged.
- Push while empty and capture in same cycle: not possible; new entry first becomes head next cycle (no fall-through).
- o_out_y/o_out_valid stable while o_out_valid && !out_ready_i.
- Result ordering strictly FIFO; no reordering, no dropping.

## Timing
- Reset (async assert, sync-released by environment): write/read pointers 0, o_count 0, o_out_valid 0, o_out_y 0, o_in_ready 1, o_sh_* 0. FIFO storage need not be cleared.
- Reset mid-operation: all queued commands and pending result discarded; no output after release until new push.
- Latency: command accepted at edge N → head at cycle N+1 → o_out_valid high from edge N+1 (cycle N+2 observable), given output register free.
- Throughput: 1 result/cycle with in_valid_i and out_ready_i held high.
- Capacity under full backpressure: DEPTH+1 commands (DEPTH in FIFO, 1 in output register) before o_in_ready drops.
- Rotator path (o_sh_* → sh_y_i) is single-cycle combinational; budgeted within one clock.

## Configuration
- SHIFT_ISSUE_OPCOUNT_EN defined: adds output o_ops_done (16 bits), reset 0, increments by 1 on each completed output handshake (o_out_valid && out_ready_i), wraps 0xFFFF → 0x0000.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Single right rotate: push 0x8000_0001, s=1, right=1, out_ready_i=1 → o_out_y = 0xC000_0000, o_out_valid high for exactly one cycle, two edges after push.
- Single left rotate: push 0x1234_5678, s=8, right=0 → o_out_y = 0x3456_7812; s=0 of 0xDEAD_BEEF → 0xDEAD_BEEF.
- Backpressure fill (DEPTH=4): out_ready_i=0, push 6 commands back-to-back → 5 accepted, o_in_ready low after 5th, o_count=4; release out_ready_i → 5 results in push order, one per cycle.
- Streaming: 32 pushes of 0x0000_0001 left by k=0..31, out_ready_i=1 → outputs 1<<k in order, no bubbles after first, o_count ≤ 1.
- Reset mid-stream: with 3 queued and o_out_valid=1, pulse rst_ni low → immediately o_out_valid=0, o_count=0, o_in_ready=1; no stale result after release.
- With SHIFT_ISSUE_OPCOUNT_EN: 10 completed handshakes plus 2 stalled cycles → o_ops_done=10.
